// File: rtl/ovi_pkg.sv
// Shared types and constants for the OVI memory-op responder.
// Holds the load_seq_id field layout, the beat width and the op FSM states.
package ovi_pkg;

    localparam int OVI_BEAT_BITS = 512;
    localparam int OVI_MASK_BITS = OVI_BEAT_BITS / 8;

    localparam int SEQ_W        = 34;
    localparam int SEQ_VREG_LSB = 0;
    localparam int SEQ_VREG_W   = 5;
    localparam int SEQ_ELID_LSB = 5;
    localparam int SEQ_ELID_W   = 11;
    localparam int SEQ_ELOFF_LSB = 16;
    localparam int SEQ_ELOFF_W  = 6;
    localparam int SEQ_ELCNT_LSB = 22;
    localparam int SEQ_ELCNT_W  = 7;
    localparam int SEQ_SBID_LSB = 29;
    localparam int SEQ_SBID_W   = 5;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT_SYNC,
        MS_XFER,
        MS_DONE
    } memop_state_t;

    function automatic logic [SEQ_ELCNT_W-1:0] el_count_f(
        input logic [1:0] eew_log2
    );
        logic [SEQ_ELCNT_W-1:0] ec;
        unique case (eew_log2)
            2'd0: ec = 7'd64;
            2'd1: ec = 7'd32;
            2'd2: ec = 7'd16;
            2'd3: ec = 7'd8;
        endcase
        return ec;
    endfunction

endpackage

// File: rtl/ovi_beat_fifo.sv
// Small synchronous FIFO for store beats.
// Pushes while full and pops while empty are ignored.
module ovi_beat_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ovi_memop_responder.sv
// Core-side OVI memory-op responder: one LSU command at a time,
// store beats to memory with credit return, load beats back with seq ids.
module ovi_memop_responder
    import ovi_pkg::*;
#(
    parameter int STORE_CREDITS = 32,
    parameter int SFIFO_DEPTH   = 4,
    parameter int MEM_IDX_W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_is_store,
    input  logic [4:0]               cmd_sb_id,
    input  logic [4:0]               cmd_vreg,
    input  logic [1:0]               cmd_eew_log2,
    input  logic [4:0]               cmd_beats,
    input  logic [MEM_IDX_W-1:0]     cmd_base_idx,
    input  logic                     memop_sync_start,
    output logic                     memop_sync_end,
    input  logic                     store_valid,
    input  logic [OVI_BEAT_BITS-1:0] store_data,
    output logic                     store_credit,
    output logic                     load_valid,
    output logic [OVI_BEAT_BITS-1:0] load_data,
    output logic [SEQ_W-1:0]         load_seq_id,
    output logic [OVI_MASK_BITS-1:0] load_mask,
    output logic                     load_mask_valid,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [MEM_IDX_W-1:0]     mem_req_idx,
    output logic [OVI_BEAT_BITS-1:0] mem_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [OVI_BEAT_BITS-1:0] mem_rsp_rdata
);

    // Buffer can never usefully exceed what the VPU may have in flight.
    localparam int FDEPTH =
        (SFIFO_DEPTH < STORE_CREDITS) ? SFIFO_DEPTH : STORE_CREDITS;

    memop_state_t state_q, state_d;

    logic                 live_q;
    logic                 sync_seen_q;
    logic                 is_store_q;
    logic [4:0]           sb_q;
    logic [4:0]           vreg_q;
    logic [1:0]           eew_q;
    logic [4:0]           beats_q;
    logic [MEM_IDX_W-1:0] base_q;
    logic [4:0]           wr_cnt_q;
    logic [4:0]           rd_iss_q;
    logic [4:0]           rd_done_q;
    logic [1:0]           outst_q;
    logic                 err_overflow;
    logic                 err_unexpected;

    logic                     cmd_hs;
    logic                     xfer_st;
    logic                     xfer_ld;
    logic                     st_req;
    logic                     ld_req;
    logic                     req_hs;
    logic                     st_hs;
    logic                     ld_hs;
    logic                     rsp_take;
    logic                     fifo_push;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [OVI_BEAT_BITS-1:0] fifo_rdata;
    logic [4:0]               req_cnt;
    logic [SEQ_ELCNT_W-1:0]   ec;
    logic [SEQ_ELID_W-1:0]    el_id;
    logic [SEQ_W-1:0]         seq_nx;

    assign cmd_ready = (state_q == MS_IDLE) && live_q;
    assign cmd_hs    = cmd_ready && cmd_valid;
    assign xfer_st   = (state_q == MS_XFER) && is_store_q;
    assign xfer_ld   = (state_q == MS_XFER) && !is_store_q;
    assign fifo_push = xfer_st && store_valid;

    assign st_req = xfer_st && !fifo_empty && (wr_cnt_q < beats_q);
    assign ld_req = xfer_ld && (rd_iss_q < beats_q) && (outst_q < 2'd2);

    assign mem_req_valid = st_req || ld_req;
    assign mem_req_we    = st_req;
    assign req_cnt       = st_req ? wr_cnt_q : rd_iss_q;
    assign mem_req_idx   = mem_req_valid ?
                           base_q + MEM_IDX_W'(req_cnt) : '0;
    assign mem_wdata     = st_req ? fifo_rdata : '0;

    assign req_hs   = mem_req_valid && mem_req_ready;
    assign st_hs    = req_hs && mem_req_we;
    assign ld_hs    = req_hs && !mem_req_we;
    assign rsp_take = xfer_ld && mem_rsp_valid;

    assign memop_sync_end  = (state_q == MS_DONE);
    assign load_mask       = '1;
    assign load_mask_valid = 1'b0;

    assign ec     = el_count_f(eew_q);
    assign el_id  = 11'(rd_done_q) * 11'(ec);
    assign seq_nx = {sb_q, ec, 6'd0, el_id, vreg_q};

    ovi_beat_fifo #(
        .DEPTH (FDEPTH),
        .WIDTH (OVI_BEAT_BITS)
    ) u_sfifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (store_data),
        .pop   (st_hs),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MS_IDLE: begin
                if (cmd_hs) state_d = MS_WAIT_SYNC;
            end
            MS_WAIT_SYNC: begin
                if (sync_seen_q) state_d = MS_XFER;
            end
            MS_XFER: begin
                if (is_store_q) begin
                    if (wr_cnt_q == beats_q) state_d = MS_DONE;
                end else if (load_valid && (rd_done_q == beats_q)) begin
                    state_d = MS_DONE;
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q      <= 1'b0;
            sync_seen_q <= 1'b0;
            is_store_q  <= 1'b0;
            sb_q        <= '0;
            vreg_q      <= '0;
            eew_q       <= '0;
            beats_q     <= 5'd1;
            base_q      <= '0;
        end else begin
            live_q <= 1'b1;
            // A sync pulse may arrive before the command; remember it.
            if ((state_q == MS_WAIT_SYNC) && sync_seen_q) begin
                sync_seen_q <= 1'b0;
            end else if (memop_sync_start) begin
                sync_seen_q <= 1'b1;
            end
            if (cmd_hs) begin
                is_store_q <= cmd_is_store;
                sb_q       <= cmd_sb_id;
                vreg_q     <= cmd_vreg;
                eew_q      <= cmd_eew_log2;
                beats_q    <= (cmd_beats == '0) ? 5'd1 : cmd_beats;
                base_q     <= cmd_base_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            rd_iss_q  <= '0;
            rd_done_q <= '0;
            outst_q   <= '0;
        end else if (cmd_hs) begin
            wr_cnt_q  <= '0;
            rd_iss_q  <= '0;
            rd_done_q <= '0;
            outst_q   <= '0;
        end else begin
            if (st_hs) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (ld_hs) rd_iss_q <= rd_iss_q + 1'b1;
            if (rsp_take) rd_done_q <= rd_done_q + 1'b1;
            unique case ({ld_hs, rsp_take})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_credit   <= 1'b0;
            load_valid     <= 1'b0;
            load_data      <= '0;
            load_seq_id    <= '0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            store_credit <= st_hs;
            load_valid   <= rsp_take;
            if (rsp_take) begin
                load_data   <= mem_rsp_rdata;
                load_seq_id <= seq_nx;
            end
            if (fifo_push && fifo_full) err_overflow <= 1'b1;
            if (store_valid && !xfer_st) err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ovi_memop_responder.sv
// Randomised scoreboard bench for ovi_memop_responder.
// Behavioural memory, VPU credit pacing and per-op expectations.
module tb_ovi_memop_responder;
    import ovi_pkg::*;

    localparam int CRED = 4;
    localparam int IW   = 10;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_is_store;
    logic [4:0] cmd_sb_id, cmd_vreg, cmd_beats;
    logic [1:0] cmd_eew_log2;
    logic [IW-1:0] cmd_base_idx;
    logic memop_sync_start, memop_sync_end;
    logic store_valid, store_credit;
    logic [511:0] store_data;
    logic load_valid, load_mask_valid;
    logic [511:0] load_data;
    logic [33:0] load_seq_id;
    logic [63:0] load_mask;
    logic mem_req_valid, mem_req_ready, mem_req_we;
    logic [IW-1:0] mem_req_idx;
    logic [511:0] mem_wdata;
    logic mem_rsp_valid = 1'b0;
    logic [511:0] mem_rsp_rdata = '0;

    always #5 clk = ~clk;

    ovi_memop_responder #(
        .STORE_CREDITS (CRED),
        .SFIFO_DEPTH   (4),
        .MEM_IDX_W     (IW)
    ) dut (
        .clk (clk), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_is_store (cmd_is_store), .cmd_sb_id (cmd_sb_id),
        .cmd_vreg (cmd_vreg), .cmd_eew_log2 (cmd_eew_log2),
        .cmd_beats (cmd_beats), .cmd_base_idx (cmd_base_idx),
        .memop_sync_start (memop_sync_start),
        .memop_sync_end (memop_sync_end),
        .store_valid (store_valid), .store_data (store_data),
        .store_credit (store_credit),
        .load_valid (load_valid), .load_data (load_data),
        .load_seq_id (load_seq_id), .load_mask (load_mask),
        .load_mask_valid (load_mask_valid),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_req_we (mem_req_we), .mem_req_idx (mem_req_idx),
        .mem_wdata (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid), .mem_rsp_rdata (mem_rsp_rdata)
    );

    typedef struct { logic [IW-1:0] idx; logic [511:0] data; } wr_t;
    typedef struct { logic [511:0] data; logic [33:0] seq; } ld_t;
    typedef struct { logic [IW-1:0] idx; int due; } rd_t;

    logic [511:0] tbmem [1024];
    wr_t wq[$];
    ld_t lq[$];
    rd_t rq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int credits_rx = 0;
    int sync_cnt = 0;
    int outst = 0;
    int max_outst = 0;
    int rsp_delay = 1;
    int rdy_pct = 100;
    bit stall = 1'b0;
    bit prev_pend = 1'b0;
    logic [11:0] prev_ctl;
    logic [511:0] prev_wd;
    wr_t w_m;
    ld_t l_m;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Sequence id straight from the field rules: count = 64 / element bytes.
    function automatic logic [33:0] exp_seq(logic [4:0] sb, logic [1:0] eew,
                                            int beat, logic [4:0] vreg);
        int ec;
        int id;
        ec = 64 / (1 << eew);
        id = (beat * ec) % 2048;
        return {sb, 7'(ec), 6'd0, 11'(id), vreg};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        mem_req_ready = !stall && ($urandom_range(99) < rdy_pct);
        if (reset) begin
            rq.delete();
            mem_rsp_valid = 1'b0;
        end else if (rq.size() > 0 && cyc >= rq[0].due) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = tbmem[rq[0].idx];
            void'(rq.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            outst = 0;
            prev_pend = 1'b0;
            wq.delete();
            lq.delete();
        end else begin
            if (prev_pend) begin
                chk("req_hold_ctl", {mem_req_valid, mem_req_we, mem_req_idx},
                    prev_ctl);
                chk("req_hold_data", mem_wdata, prev_wd);
            end
            prev_pend = mem_req_valid && !mem_req_ready;
            prev_ctl  = {mem_req_valid, mem_req_we, mem_req_idx};
            prev_wd   = mem_wdata;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w_m = wq.pop_front();
                        chk("wr_idx", mem_req_idx, w_m.idx);
                        chk("wr_data", mem_wdata, w_m.data);
                    end
                    tbmem[mem_req_idx] = mem_wdata;
                end else begin
                    rq.push_back('{idx: mem_req_idx, due: cyc + rsp_delay});
                    outst++;
                end
            end
            if (mem_rsp_valid) outst--;
            if (outst > max_outst) max_outst = outst;
            if (load_valid) begin
                if (lq.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    l_m = lq.pop_front();
                    chk("load_data", load_data, l_m.data);
                    chk("load_seq_id", load_seq_id, l_m.seq);
                    chk("load_mask", {load_mask_valid, load_mask},
                        {1'b0, {64{1'b1}}});
                end
            end
            if (store_credit) credits_rx++;
            if (memop_sync_end) begin
                sync_cnt++;
                chk("end_drained", wq.size() + lq.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        memop_sync_start = 1'b1;
        tick();
        memop_sync_start = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_sync_end", memop_sync_end, 0);
        chk("rst_credit", store_credit, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_seq_id", load_seq_id, 0);
        chk("rst_mask", {load_mask_valid, load_mask}, {1'b0, {64{1'b1}}});
        chk("rst_req", {mem_req_valid, mem_req_we, mem_req_idx}, 0);
        chk("rst_wdata", mem_wdata, 0);
    endtask

    task automatic issue_cmd(bit st, int beats, logic [1:0] eew,
                             logic [4:0] vreg, logic [4:0] sb,
                             logic [IW-1:0] base);
        int g;
        bit ok;
        g = 0;
        cmd_valid    = 1'b1;
        cmd_is_store = st;
        cmd_beats    = 5'(beats);
        cmd_eew_log2 = eew;
        cmd_vreg     = vreg;
        cmd_sb_id    = sb;
        cmd_base_idx = base;
        do begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
            g++;
        end while (!ok && g < 100);
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept", 0, 1);
    endtask

    task automatic run_op(bit st, int beats, logic [1:0] eew,
                          logic [4:0] vreg, logic [4:0] sb,
                          logic [IW-1:0] base, bit sync_first,
                          int stall_cyc, int dly);
        int n;
        int c0;
        int s0;
        int sent;
        int waitc;
        logic [511:0] d[$];
        logic [IW-1:0] a;
        n = (beats == 0) ? 1 : beats;
        c0 = credits_rx;
        s0 = sync_cnt;
        sent = 0;
        rsp_delay = dly;
        stall = (stall_cyc > 0);
        for (int i = 0; i < n; i++) begin
            a = base + IW'(i);
            if (st) begin
                d.push_back(rand512());
                wq.push_back('{idx: a, data: d[i]});
            end else begin
                lq.push_back('{data: tbmem[a],
                               seq: exp_seq(sb, eew, i, vreg)});
            end
        end
        if (sync_first) pulse_sync();
        issue_cmd(st, beats, eew, vreg, sb, base);
        if (!sync_first) pulse_sync();
        repeat (3) tick();
        if (st) begin
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        int g;
                        g = 0;
                        while (CRED - sent + (credits_rx - c0) <= 0 &&
                               g < 2000) begin
                            tick();
                            g++;
                        end
                        store_valid = 1'b1;
                        store_data  = d[i];
                        tick();
                        store_valid = 1'b0;
                        sent++;
                        if ($urandom_range(3) == 0) tick();
                    end
                end
                begin
                    if (stall_cyc > 0) begin
                        repeat (stall_cyc) tick();
                        chk("no_credit_in_stall", credits_rx - c0, 0);
                        stall = 1'b0;
                    end
                end
            join
        end
        waitc = 0;
        while (sync_cnt == s0 && waitc < 3000) begin
            tick();
            waitc++;
        end
        repeat (3) tick();
        chk("one_sync_end", sync_cnt - s0, 1);
        chk("idle_ready", cmd_ready, 1);
        chk("no_flags", {dut.err_overflow, dut.err_unexpected}, 0);
        if (st) chk("credits", credits_rx - c0, n);
        else chk("outst_le2", (max_outst <= 2), 1);
    endtask

    task automatic reset_mid_store();
        int s0;
        logic [511:0] d0;
        s0 = sync_cnt;
        rdy_pct = 100;
        d0 = rand512();
        wq.push_back('{idx: 10'd40, data: d0});
        pulse_sync();
        issue_cmd(1'b1, 4, 2'd0, 5'd1, 5'd9, 10'd40);
        repeat (3) tick();
        store_valid = 1'b1;
        store_data  = d0;
        tick();
        store_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        chk("rst_flags", {dut.err_overflow, dut.err_unexpected}, 0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("no_end_after_reset", sync_cnt - s0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_is_store = 1'b0;
        cmd_sb_id = '0;
        cmd_vreg = '0;
        cmd_eew_log2 = '0;
        cmd_beats = '0;
        cmd_base_idx = '0;
        memop_sync_start = 1'b0;
        store_valid = 1'b0;
        store_data = '0;
        for (int i = 0; i < 1024; i++) tbmem[i] = rand512();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        tick();
        reset = 1'b0;
        tick();

        run_op(1'b1, 2, 2'd0, 5'd0, 5'd0, 10'd5, 1'b1, 0, 1);
        run_op(1'b0, 3, 2'd2, 5'd8, 5'd3, 10'd5, 1'b0, 0, 1);
        run_op(1'b1, 6, 2'd1, 5'd2, 5'd7, 10'd100, 1'b0, 10, 1);
        run_op(1'b0, 8, 2'd0, 5'd1, 5'd2, 10'd100, 1'b1, 0, 5);

        store_valid = 1'b1;
        store_data = rand512();
        tick();
        store_valid = 1'b0;
        tick();
        chk("err_unexpected", dut.err_unexpected, 1);
        reset_mid_store();
        run_op(1'b1, 4, 2'd3, 5'd4, 5'd4, 10'd40, 1'b1, 0, 1);
        run_op(1'b0, 0, 2'd3, 5'd31, 5'd31, 10'd1023, 1'b0, 0, 2);

        for (int k = 0; k < 20; k++) begin
            rdy_pct = $urandom_range(100, 30);
            run_op(1'($urandom_range(1)), $urandom_range(16),
                   2'($urandom_range(3)), 5'($urandom_range(31)),
                   5'($urandom_range(31)), IW'($urandom_range(1023)),
                   1'($urandom_range(1)), 0, $urandom_range(6, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ovi_memop_responder.md
Name: ovi_memop_responder

Overview:
Core-side (CPU-end) responder for the Open Vector Interface memory-op channel. It pairs with the VPU wrapper, which raises memop_sync_start, streams store beats and expects load beats plus memop_sync_end. A scalar LSU hands it one vector memory command at a time. It moves 512-bit beats between OVI and a simple single-port memory port, returns store credits, generates load_seq_id and closes each op with memop_sync_end.

Parameters:
STORE_CREDITS, 32, credits the VPU starts with; also the sizing bound for outstanding store beats.
SFIFO_DEPTH, 4, store beat buffer entries (power of 2, at most STORE_CREDITS).
MEM_IDX_W, 10, memory beat-index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  LSU command valid
cmd_ready  out  1  accepting command (IDLE only)
cmd_is_store  in  1  1=store, 0=load
cmd_sb_id  in  5  scoreboard id of the op
cmd_vreg  in  5  base vector register
cmd_eew_log2  in  2  0..3 = 8/16/32/64-bit elements
cmd_beats  in  5  512-bit beats, 1..16 (0 is treated as 1)
cmd_base_idx  in  MEM_IDX_W  first memory beat index
memop_sync_start  in  1  VPU sync request pulse
memop_sync_end  out  1  one-cycle completion pulse
store_valid  in  1  store beat valid
store_data  in  512  store beat
store_credit  out  1  one-cycle pulse per freed store slot
load_valid  out  1  load beat valid
load_data  out  512  load beat
load_seq_id  out  34  {sb_id[33:29], el_count[28:22], el_off[21:16], el_id[15:5], v_reg[4:0]}
load_mask  out  64  byte mask, always all-ones
load_mask_valid  out  1  always 0
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts
mem_req_we  out  1  write request
mem_req_idx  out  MEM_IDX_W  beat index
mem_wdata  out  512  write data
mem_rsp_valid  in  1  read data valid, in request order, at least 1 cycle after acceptance
mem_rsp_rdata  in  512  read data

Behaviour:
- Reset values: cmd_ready=0, memop_sync_end=0, store_credit=0, load_valid=0, load_data=0, load_seq_id=0, load_mask='1, load_mask_valid=0, mem_req_valid=0, mem_req_we=0, mem_req_idx=0, mem_wdata=0. FSM returns to IDLE. FIFO and counters clear. Reset mid-op abandons the op; no memop_sync_end is issued.
- FSM states: IDLE, WAIT_SYNC, XFER, DONE.
  - IDLE: cmd_ready=1. On cmd_valid, latch all command fields and go to WAIT_SYNC.
  - WAIT_SYNC: go to XFER once sync_seen is set. sync_seen is a sticky flag set by a memop_sync_start pulse in any state, including IDLE before the command arrives. It clears on entry to XFER.
  - XFER (store): each store_valid cycle pushes the beat into the FIFO.
    - If store_valid arrives with the FIFO full, flag sticky err_overflow (internal, visible in simulation) and drop the beat. This is a protocol violation that credits must prevent.
    - FIFO head drives mem_req with we=1 and idx=base+wr_cnt. On handshake: pop, wr_cnt++, and pulse store_credit in the next cycle.
    - Go to DONE when wr_cnt==beats.
  - XFER (load):
    - Issue mem reads idx=base+rd_issued while rd_issued<beats. Hold at most 2 reads outstanding.
    - Each mem_rsp_valid produces load_valid for exactly 1 cycle, registered (1-cycle latency), with load_data=rdata.
    - load_seq_id fields per beat: sb_id=cmd_sb_id; el_count=64>>eew_log2 (64/32/16/8); el_off=0; el_id=beat_num*el_count (11-bit, wraps); v_reg=cmd_vreg.
    - Go to DONE when the beats-th load_valid is issued.
  - DONE: memop_sync_end=1 for exactly one cycle, then IDLE.
- Store credit counter inside the block: none. The VPU owns the count; this block only guarantees one credit pulse per accepted beat.
- store_valid outside XFER-store is ignored, and err_unexpected is flagged.
- mem_req_valid, once raised, holds with stable fields until mem_req_ready.

Decomposition:
- Shared package ovi_pkg:
  - seq_id field offsets/widths.
  - OVI_BEAT_BITS=512.
  - memop state enum.
  - Function el_count_f(eew_log2).
- One sub-module: ovi_beat_fifo, a parameterised synchronous FIFO with push/pop/full/empty and async active-high reset.

Test Plan:
- Store, 2 beats, base_idx=5, sync before cmd → mem writes to idx 5 then 6 with matching data; exactly 2 store_credit pulses; one memop_sync_end; back to IDLE.
- Load, 3 beats, eew_log2=2, vreg=8, sb_id=3 → 3 load_valid; seq ids have el_count=16, el_id=0/16/32, v_reg=8, sb_id=3; memop_sync_end after the 3rd beat.
- Store of 6 beats with mem_req_ready low for 10 cycles and 4 beats sent → FIFO fills, no credits; on ready, the 4 beats drain in order with 4 credits; remaining beats complete; no overflow flag.
- Load with mem_rsp delayed 5 cycles → never more than 2 reads outstanding; load_data order matches idx order.
- Reset asserted in XFER after 1 of 4 store beats → all outputs return to reset values; no memop_sync_end; the next command completes normally.
- cmd_beats=0 and eew_log2=3 load → treated as 1 beat with el_count=8; single load_valid then memop_sync_end.
